// File: rtl/lutram_fifo32.sv
// 32-entry first-word-fall-through FIFO on distributed dual-port RAM.
// RAM holds up to 32 words; a registered output stage holds the head word.

module lutram_fifo32_ram32x1d (
   input  logic       clk,
   input  logic       we,
   input  logic       d,
   input  logic [4:0] a,
   input  logic [4:0] dpra,
   output logic       dpo
);
   logic [31:0] bits_q;

   // Storage is not reset: stale bits are masked by the FIFO's VALID flag.
   always_ff @(posedge clk) begin
      if (we) bits_q[a] <= d;
   end

   assign dpo = bits_q[dpra];
endmodule

module lutram_fifo32 #(
   parameter int WIDTH      = 8,
   parameter int AFULL_THR  = 28,
   parameter int AEMPTY_THR = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             WR_EN,
   input  logic [WIDTH-1:0] DIN,
   output logic             FULL,
   input  logic             RD_EN,
   output logic [WIDTH-1:0] DOUT,
   output logic             VALID,
   output logic [5:0]       LEVEL,
   output logic             AFULL,
   output logic             AEMPTY,
   output logic             OVF,
   output logic             UDF
);
   logic [4:0]       wr_ptr_q, wr_ptr_d;
   logic [4:0]       rd_ptr_q, rd_ptr_d;
   logic [5:0]       mem_cnt_q, mem_cnt_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;
   logic [WIDTH-1:0] ram_rd;
   logic             push, pop, load;

   assign FULL = (mem_cnt_q == 6'd32);
   assign push = WR_EN && !FULL;
   assign pop  = RD_EN && valid_q;
   // Refill the output stage whenever it is empty or being consumed.
   assign load = (!valid_q || pop) && (mem_cnt_q != 6'd0);

   for (genvar b = 0; b < WIDTH; b++) begin : g_col
      lutram_fifo32_ram32x1d u_col (
         .clk  (CLK),
         .we   (push),
         .d    (DIN[b]),
         .a    (wr_ptr_q),
         .dpra (rd_ptr_q),
         .dpo  (ram_rd[b])
      );
   end

   always_comb begin
      wr_ptr_d  = wr_ptr_q + {4'd0, push};
      rd_ptr_d  = rd_ptr_q + {4'd0, load};
      mem_cnt_d = mem_cnt_q + {5'd0, push} - {5'd0, load};
      valid_d   = valid_q;
      dout_d    = dout_q;
      ovf_d     = ovf_q || (WR_EN && FULL);
      udf_d     = udf_q || (RD_EN && !valid_q);
      if (load) begin
         dout_d  = ram_rd;
         valid_d = 1'b1;
      end else if (pop) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         mem_cnt_q <= '0;
         valid_q   <= 1'b0;
         dout_q    <= '0;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         mem_cnt_q <= mem_cnt_d;
         valid_q   <= valid_d;
         dout_q    <= dout_d;
         ovf_q     <= ovf_d;
         udf_q     <= udf_d;
      end
   end

   assign DOUT   = dout_q;
   assign VALID  = valid_q;
   assign OVF    = ovf_q;
   assign UDF    = udf_q;
   assign LEVEL  = mem_cnt_q + {5'd0, valid_q};
   assign AFULL  = (32'(LEVEL) >= 32'(AFULL_THR));
   assign AEMPTY = (32'(LEVEL) <= 32'(AEMPTY_THR));
endmodule

// File: tb/tb_lutram_fifo32.sv
// Directed + random bench for lutram_fifo32 with a queue scoreboard.
// A second instance with thresholds 16/2 sees the same stimulus.

module tb_lutram_fifo32;
   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       WR_EN = 1'b0;
   logic       RD_EN = 1'b0;
   logic [7:0] DIN = 8'h00;

   logic       full, valid, afull, aempty, ovf, udf;
   logic [7:0] dout;
   logic [5:0] level;
   logic       full2, valid2, afull2, aempty2, ovf2, udf2;
   logic [7:0] dout2;
   logic [5:0] level2;

   int tests = 0;
   int failed = 0;

   // scoreboard / reference state
   logic [7:0] q[$];
   int         m_cnt = 0;
   bit         m_valid = 0;
   logic [7:0] m_dout = 8'h00;
   bit         m_ovf = 0, m_udf = 0;

   always #5 CLK = ~CLK;

   lutram_fifo32 #(.WIDTH(8), .AFULL_THR(28), .AEMPTY_THR(4)) u_dut (
      .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .DIN(DIN), .FULL(full),
      .RD_EN(RD_EN), .DOUT(dout), .VALID(valid), .LEVEL(level),
      .AFULL(afull), .AEMPTY(aempty), .OVF(ovf), .UDF(udf));

   lutram_fifo32 #(.WIDTH(8), .AFULL_THR(16), .AEMPTY_THR(2)) u_thr (
      .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .DIN(DIN), .FULL(full2),
      .RD_EN(RD_EN), .DOUT(dout2), .VALID(valid2), .LEVEL(level2),
      .AFULL(afull2), .AEMPTY(aempty2), .OVF(ovf2), .UDF(udf2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      int lvl;
      lvl = q.size();
      chk("valid",   valid,  m_valid);
      chk("dout",    dout,   m_dout);
      chk("level",   level,  lvl);
      chk("full",    full,   m_cnt == 32);
      chk("afull",   afull,  lvl >= 28);
      chk("aempty",  aempty, lvl <= 4);
      chk("ovf",     ovf,    m_ovf);
      chk("udf",     udf,    m_udf);
      chk("level2",  level2, lvl);
      chk("afull2",  afull2, lvl >= 16);
      chk("aempty2", aempty2, lvl <= 2);
      chk("dout2",   dout2,  m_dout);
   endtask

   // Drive one cycle of stimulus, advance the reference, then compare.
   task automatic step(input bit wr, input logic [7:0] d, input bit rd, input bit rst);
      bit push, pop, load;
      WR_EN = wr; DIN = d; RD_EN = rd; RST = rst;
      if (rst) begin
         q.delete(); m_cnt = 0; m_valid = 0; m_dout = 8'h00; m_ovf = 0; m_udf = 0;
      end else begin
         push = wr && (m_cnt != 32);
         pop  = rd && m_valid;
         load = (!m_valid || pop) && (m_cnt != 0);
         if (wr && m_cnt == 32) m_ovf = 1;
         if (rd && !m_valid) m_udf = 1;
         if (load) m_dout = m_valid ? q[1] : q[0];
         if (pop) void'(q.pop_front());
         if (push) q.push_back(d);
         m_cnt = m_cnt + int'(push) - int'(load);
         if (load) m_valid = 1;
         else if (pop) m_valid = 0;
      end
      @(posedge CLK); #1;
      check_all();
   endtask

   initial begin
      #1;
      // reset
      step(0, 8'h00, 0, 1);
      step(0, 8'h00, 0, 1);
      chk("rst_dout", dout, 8'h00);
      chk("rst_level", level, 6'd0);
      chk("rst_aempty", aempty, 1'b1);

      // single word latency
      step(1, 8'hA5, 0, 0);
      chk("sw_valid_e1", valid, 1'b0);
      step(0, 8'h00, 0, 0);
      chk("sw_valid_e2", valid, 1'b1);
      chk("sw_dout", dout, 8'hA5);
      chk("sw_level", level, 6'd1);
      step(0, 8'h00, 1, 0);
      chk("sw_pop_level", level, 6'd0);

      // fill to 33 words
      for (int i = 0; i <= 32; i++) step(1, 8'(i), 0, 0);
      chk("fill_full", full, 1'b1);
      chk("fill_level", level, 6'd33);
      step(1, 8'hFF, 0, 0);
      chk("fill_ovf", ovf, 1'b1);
      chk("fill_level_hold", level, 6'd33);
      // full with simultaneous read: write refused
      step(1, 8'hEE, 1, 0);
      chk("full_rw_level", level, 6'd32);

      // drain: one word per cycle, no bubbles
      for (int i = 1; i <= 32; i++) begin
         chk("drain_valid", valid, 1'b1);
         chk("drain_seq", dout, 32'(i));
         step(0, 8'h00, 1, 0);
      end
      chk("drain_empty", valid, 1'b0);
      step(0, 8'h00, 1, 0);
      chk("drain_udf", udf, 1'b1);

      // wrap streaming at constant level
      for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 0, 0);
      step(0, 8'h00, 0, 0);
      chk("wrap_pre_level", level, 6'd5);
      for (int i = 0; i < 64; i++) begin
         step(1, 8'(8'h80 + i), 1, 0);
         chk("wrap_level", level, 6'd5);
      end
      for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0);

      // reset mid-operation
      for (int i = 0; i < 10; i++) step(1, 8'(8'hC0 + i), 0, 0);
      step(0, 8'h00, 0, 0);
      chk("mid_level", level, 6'd10);
      chk("mid_ovf_udf", {ovf, udf}, 2'b11);
      step(0, 8'h00, 0, 1);
      chk("mr_level", level, 6'd0);
      chk("mr_valid", valid, 1'b0);
      chk("mr_flags", {ovf, udf}, 2'b00);
      chk("mr_dout", dout, 8'h00);
      step(1, 8'h3C, 0, 0);
      chk("mr_lat1", valid, 1'b0);
      step(0, 8'h00, 0, 0);
      chk("mr_first", dout, 8'h3C);
      chk("mr_first_v", valid, 1'b1);

      // random traffic, both flags exercised by the scoreboard checks
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 45), 1'b0);
      for (int i = 0; i < 40; i++) step(0, 8'h00, 1, 0);
      chk("final_empty", valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
